// File: rtl/calc_sequencer.sv
// Operand/operation sequencer for a small add/subtract datapath, driven by two debounced pushbuttons.
// Strobes are PULSE_W cycles wide, starting the cycle after a press. Step presses that arrive while busy are dropped.
module calc_debounce #(
    parameter logic [15:0] DB_COUNT = 16'd50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_press
);
    logic        r_s1;
    logic        r_s2;
    logic        r_db;
    logic        r_db_q;
    logic [15:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b1;
            r_s2   <= 1'b1;
            r_db   <= 1'b1;
            r_db_q <= 1'b1;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_key;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            // Any sample that matches the accepted level restarts the run.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt >= DB_COUNT - 16'd1) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_press = r_db_q & ~r_db;
endmodule

module calc_sequencer #(
    parameter logic [15:0] DB_COUNT = 16'd50000,
    parameter logic [2:0]  PULSE_W  = 3'd2
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       KEY_STEP,
    input  logic       KEY_CANCEL,
    input  logic [7:0] SW,
    input  logic       SW_OP,
    output logic [7:0] X,
    output logic       InA,
    output logic       InB,
    output logic       Out,
    output logic       Clear,
    output logic       Add_Subtract,
    output logic [1:0] STATE,
    output logic       BUSY
);
    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_EXEC = 2'b10,
        S_SHOW = 2'b11
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_x, w_x_nxt;
    logic       r_as, w_as_nxt;
    logic       r_ina, w_ina_nxt;
    logic       r_inb, w_inb_nxt;
    logic       r_out, w_out_nxt;
    logic       r_clr, w_clr_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_rst_hold;

    logic w_step_press;
    logic w_cancel_press;
    logic w_active;
    logic w_step_go;

    calc_debounce #(.DB_COUNT(DB_COUNT)) u_db_step (
        .i_clk   (CLK),
        .i_rst_n (CLR),
        .i_key   (KEY_STEP),
        .o_press (w_step_press)
    );

    calc_debounce #(.DB_COUNT(DB_COUNT)) u_db_cancel (
        .i_clk   (CLK),
        .i_rst_n (CLR),
        .i_key   (KEY_CANCEL),
        .o_press (w_cancel_press)
    );

    assign w_active  = r_ina | r_inb | r_out | r_clr;
    assign w_step_go = w_step_press & ~w_cancel_press & ~w_active;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            r_state    <= S_A;
            r_x        <= '0;
            r_as       <= 1'b0;
            r_ina      <= 1'b0;
            r_inb      <= 1'b0;
            r_out      <= 1'b0;
            r_clr      <= 1'b0;
            r_cnt      <= '0;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_as       <= w_as_nxt;
            r_ina      <= w_ina_nxt;
            r_inb      <= w_inb_nxt;
            r_out      <= w_out_nxt;
            r_clr      <= w_clr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rst_hold <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_as_nxt    = r_as;
        w_ina_nxt   = r_ina;
        w_inb_nxt   = r_inb;
        w_out_nxt   = r_out;
        w_clr_nxt   = r_clr;
        w_cnt_nxt   = r_cnt;

        // r_cnt holds the strobe cycles still to come after the current one.
        if (w_active) begin
            if (r_cnt == 3'd0) begin
                w_ina_nxt = 1'b0;
                w_inb_nxt = 1'b0;
                w_out_nxt = 1'b0;
                w_clr_nxt = 1'b0;
                if (r_ina)      w_state_nxt = S_B;
                else if (r_inb) w_state_nxt = S_EXEC;
                else if (r_out) w_state_nxt = S_SHOW;
            end else begin
                w_cnt_nxt = r_cnt - 3'd1;
            end
        end

        if (w_cancel_press) begin
            w_ina_nxt   = 1'b0;
            w_inb_nxt   = 1'b0;
            w_out_nxt   = 1'b0;
            w_clr_nxt   = 1'b1;
            w_cnt_nxt   = PULSE_W - 3'd1;
            w_state_nxt = S_A;
            w_x_nxt     = '0;
        end else if (w_step_go) begin
            case (r_state)
                S_A: begin
                    w_x_nxt   = SW;
                    w_ina_nxt = 1'b1;
                    w_cnt_nxt = PULSE_W - 3'd1;
                end
                S_B: begin
                    w_x_nxt   = SW;
                    w_inb_nxt = 1'b1;
                    w_cnt_nxt = PULSE_W - 3'd1;
                end
                S_EXEC: begin
                    w_as_nxt  = SW_OP;
                    w_out_nxt = 1'b1;
                    w_cnt_nxt = PULSE_W - 3'd1;
                end
                S_SHOW: begin
                    w_state_nxt = S_A;
                end
            endcase
        end
    end

    assign X            = r_x;
    assign InA          = r_ina;
    assign InB          = r_inb;
    assign Out          = r_out;
    assign Clear        = r_clr | r_rst_hold;
    assign Add_Subtract = r_as;
    assign STATE        = r_state;
    assign BUSY         = w_active | w_cancel_press | w_step_go;
endmodule
